univ_shift_reg: RTL
===================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal register: WIDTH-bit register with hold, shift-left,
//   shift-right and parallel load, async active-low reset and sync clear.
//   A shift counter flags when every loaded bit has been shifted out.
//   Used as the serialiser/deserialiser and general register stage in the labs.
// PARAMETERS
//   WIDTH    8   register width in bits, WIDTH >= 2
//   RST_VAL  0   value of q after reset or clear (WIDTH bits)
// PORTS
//   clk     in   1                    clock, rising edge
//   rst_n   in   1                    async reset, active low
//   en      in   1                    operation enable (does not gate clr)
//   clr     in   1                    sync clear
//   mode    in   2                    00 hold, 01 shift left, 10 shift right, 11 load
//   sin_l   in   1                    serial in at MSB on shift right
//   sin_r   in   1                    serial in at LSB on shift left
//   d       in   WIDTH                parallel load data
//   q       out  WIDTH                register contents
//   so_l    out  1                    q[WIDTH-1], combinational
//   so_r    out  1                    q[0], combinational
//   cnt     out  $clog2(WIDTH+1)      shifts since last load/clear, saturating
//   done    out  1                    one-cycle pulse, cnt reached WIDTH
// BEHAVIOUR
//   - rst_n=0: immediately, no clock needed: q=RST_VAL, cnt=0, done=0.
//   - Per rising edge, priority: clr > !en > mode.
//   - clr=1: q=RST_VAL, cnt=0, done=0, regardless of en and mode.
//   - en=0: q and cnt hold, done=0.
//   - en=1, mode 00: hold; done=0.
//   - mode 01: q <= {q[WIDTH-2:0], sin_r}.
//   - mode 10: q <= {sin_l, q[WIDTH-1:1]}.
//   - mode 11: q <= d, cnt <= 0, done=0.
//   - Shift (01/10): cnt <= cnt+1, saturates at WIDTH.
//   - done is registered: it goes to 1 on the edge where cnt moves
//     from WIDTH-1 to WIDTH; at any other edge it goes to 0.
//   - Shifts with cnt=WIDTH still shift q. cnt stays WIDTH, done stays 0.
//   - Direction changes mid-sequence count normally. The count is shifts,
//     not net position.
//   - Reset asserted mid-shift aborts at once. After release the first
//     active edge starts from RST_VAL with cnt=0.
//   - Latency: q, cnt and done update 1 cycle after the sampling edge.
//     so_l and so_r follow q with no extra delay.
// CONFIGURATION
//   USR_ROTATE_EN defined: shifts rotate.
//     - Shift left feeds q[WIDTH-1] into LSB. Shift right feeds q[0] into MSB.
//     - sin_l and sin_r are ignored. cnt and done behave as above.
//   USR_ROTATE_EN undefined: serial inputs are used exactly as listed above.
// TESTING (WIDTH=8, RST_VAL=0)
//   1 Drop rst_n mid-cycle with q=0x5A
//     -> q=0x00, cnt=0, done=0 before the next edge.
//   2 Load 0xA5, then 8x shift-left, sin_r=1
//     -> q=0x4B,0x97,0x2F,...,0xFF; cnt=8.
//     -> done=1 only in the cycle after the 8th shift.
//     -> 9th shift: q=0xFF, done=0, cnt=8.
//   3 Load 0x81, shift-right twice, sin_l=0
//     -> q=0x40, then 0x20; so_r=0, so_l=0; cnt=2.
//   4 Hold and clear: en=0, mode=01
//     -> q unchanged over 3 edges.
//     -> clr=1 with en=0: q=0x00, cnt=0 next edge.
//   5 Reload mid-count: after 5 shifts, load 0x3C
//     -> cnt=0, q=0x3C, no done pulse.
//     -> 8 more shifts give done exactly once.
//   6 Load 0x81, shift-left, sin_r=0
//     -> q=0x02 without USR_ROTATE_EN, q=0x03 with it.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register (hold / shift left / shift
// right / parallel load) with async active-low reset, sync clear and a
// saturating shift counter that pulses done when WIDTH shifts have occurred
// since the last load or clear.
// Optional build macro: USR_ROTATE_EN -- shifts rotate instead of taking the
// serial inputs.

// One register bit. Each bit gets its next value from its two neighbours,
// its own load bit, or itself.
module usr_bit_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       from_right,  // lower-order neighbour (shift left source)
    input  logic       from_left,   // higher-order neighbour (shift right source)
    input  logic       load_bit,
    output logic       q
);

    // Bit update: clear beats enable, enable gates the mode select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_BIT;
        end else if (clr) begin
            q <= RST_BIT;
        end else if (en) begin
            case (mode)
                2'b01:   q <= from_right;
                2'b10:   q <= from_left;
                2'b11:   q <= load_bit;
                default: q <= q;
            endcase
        end
    end

endmodule

module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic [1:0]                 mode,
    input  logic                       sin_l,
    input  logic                       sin_r,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic                       so_l,
    output logic                       so_r,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_chk
        $error("univ_shift_reg: WIDTH must be at least 2");
    end

    // Bits entering the ends of the register on a shift.
    logic lsb_feed;
    logic msb_feed;

`ifdef USR_ROTATE_EN
    assign lsb_feed = q[WIDTH-1];
    assign msb_feed = q[0];

    // Serial inputs are architecturally ignored when rotating.
    logic unused_sin;
    assign unused_sin = sin_l ^ sin_r;
`else
    assign lsb_feed = sin_r;
    assign msb_feed = sin_l;
`endif

    // Neighbour vectors: bit i shifts left from q[i-1], right from q[i+1].
    logic [WIDTH-1:0] from_right;
    logic [WIDTH-1:0] from_left;

    assign from_right = {q[WIDTH-2:0], lsb_feed};
    assign from_left  = {msb_feed, q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_bit_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .en         (en),
            .mode       (mode),
            .from_right (from_right[i]),
            .from_left  (from_left[i]),
            .load_bit   (d[i]),
            .q          (q[i])
        );
    end

    assign so_l = q[WIDTH-1];
    assign so_r = q[0];

    logic shift_op;
    assign shift_op = (mode == 2'b01) || (mode == 2'b10);

    // Shift counter: reset by load/clear, saturates at WIDTH; done pulses
    // only on the edge where the count first reaches WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                if (mode == 2'b11) begin
                    cnt <= '0;
                end else if (shift_op) begin
                    if (cnt != CNT_FULL)
                        cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST)
                        done <= 1'b1;
                end
            end
        end
    end

endmodule
